// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the 6-digit segment scanner: digit count, FSM states,
// 7-segment glyphs (bit=1 lit, bit[6:0]=g..a) and pin-polarity helpers.
package seg_scan_driver_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [6:0]            seg_t;
  typedef logic [NUM_DIGITS-1:0] dig_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t GLYPH_0 = 7'h3F;
  localparam seg_t GLYPH_1 = 7'h06;
  localparam seg_t GLYPH_2 = 7'h5B;
  localparam seg_t GLYPH_3 = 7'h4F;
  localparam seg_t GLYPH_4 = 7'h66;
  localparam seg_t GLYPH_5 = 7'h6D;
  localparam seg_t GLYPH_6 = 7'h7D;
  localparam seg_t GLYPH_7 = 7'h07;
  localparam seg_t GLYPH_8 = 7'h7F;
  localparam seg_t GLYPH_9 = 7'h6F;

  function automatic seg_t seg_pin(seg_t lit, bit active_low);
    return active_low ? ~lit : lit;
  endfunction

  function automatic dig_t dig_pin(dig_t sel, bit active_low);
    return active_low ? ~sel : sel;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus between the ALU (master: enable + six patterns) and the scanner
// (slave: shared segment bus, digit enables, frame strobe).
interface seg_scan_driver_if;
  import seg_scan_driver_pkg::*;

  logic en;
  seg_t d1, d2, d3, d4, d5, d6;
  seg_t seg;
  dig_t dig_en;
  logic frame_done;

  modport master (
    output en, d1, d2, d3, d4, d5, d6,
    input  seg, dig_en, frame_done
  );

  modport slave (
    input  en, d1, d2, d3, d4, d5, d6,
    output seg, dig_en, frame_done
  );

endinterface

// File: rtl/seg_scan_driver_tick_counter.sv
// Modulo-CLK_DIV slot counter, cleared by the scan FSM; flags the last blank
// clock and the last clock of each digit slot.
module seg_scan_driver_tick_counter #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int CW           = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic blank_end_o,
  output logic slot_end_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    slot_end_o  = (count_q == CW'(CLK_DIV - 1));
    blank_end_o = (BLANK_CYCLES != 0) && (count_q == CW'(BLANK_CYCLES - 1));
    count_d     = (clr_i || slot_end_o) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes six 7-seg patterns onto one segment bus; first BLANK is visible
// one clock after en is sampled, frame = 6*CLK_DIV clocks; no backpressure.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  seg_scan_driver_if.slave bus
);

  localparam int   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam seg_t SEG_OFF = seg_pin(SEG_BLANK, SEG_ACTIVE_LOW);
  localparam dig_t DIG_OFF = dig_pin('0, DIG_ACTIVE_LOW);

  state_e                         state_q;
  logic [2:0]                     idx_q, idx_d;
  logic [NUM_DIGITS-1:0][6:0]     snap_q, snap_d, d_in;
  seg_t                           seg_q;
  dig_t                           dig_q;
  logic                           frame_done_q;
  logic                           last_d;
  logic                           clr, blank_end, slot_end;

  assign d_in = {bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1};
  assign clr  = (state_q == ST_IDLE) || !bus.en;

  seg_scan_driver_tick_counter #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CW           (CW)
  ) u_tick (
    .clk         (clk),
    .rst         (reset),
    .clr_i       (clr),
    .blank_end_o (blank_end),
    .slot_end_o  (slot_end)
  );

  // Index and snapshot to use once the current slot ends; the snapshot only
  // refreshes at the frame wrap so a digit never changes while shown.
  always_comb begin
    last_d = (idx_q == 3'(NUM_DIGITS - 1));
    idx_d  = last_d ? 3'd0 : idx_q + 3'd1;
    snap_d = last_d ? d_in : snap_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!bus.en) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
        seg_q   <= SEG_OFF;
        dig_q   <= DIG_OFF;
      end else begin
        case (state_q)
          ST_IDLE: begin
            snap_q <= d_in;
            idx_q  <= '0;
            if (BLANK_CYCLES == 0) begin
              state_q <= ST_SHOW;
              seg_q   <= seg_pin(bus.d1, SEG_ACTIVE_LOW);
              dig_q   <= dig_pin(dig_t'(1), DIG_ACTIVE_LOW);
            end else begin
              state_q <= ST_BLANK;
              seg_q   <= SEG_OFF;
              dig_q   <= DIG_OFF;
            end
          end
          ST_BLANK: begin
            if (blank_end) begin
              state_q <= ST_SHOW;
              seg_q   <= seg_pin(snap_q[idx_q], SEG_ACTIVE_LOW);
              dig_q   <= dig_pin(dig_t'(1) << idx_q, DIG_ACTIVE_LOW);
            end
          end
          ST_SHOW: begin
            if (slot_end) begin
              idx_q        <= idx_d;
              snap_q       <= snap_d;
              frame_done_q <= last_d;
              // Without a blank gap the next digit goes straight on the bus.
              if (BLANK_CYCLES == 0) begin
                seg_q <= seg_pin(snap_d[idx_d], SEG_ACTIVE_LOW);
                dig_q <= dig_pin(dig_t'(1) << idx_d, DIG_ACTIVE_LOW);
              end else begin
                state_q <= ST_BLANK;
                seg_q   <= SEG_OFF;
                dig_q   <= DIG_OFF;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
          end
        endcase
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_en     = dig_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a blanking active-low instance and a no-blank
// active-high-segment instance, each checked cycle by cycle against a frame model.
module tb_seg_scan_driver;
  import seg_scan_driver_pkg::*;

  localparam int DIV   = 4;
  localparam int FRAME = 6 * DIV;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic en_a, en_b;
  logic [6:0] dv [6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  seg_scan_driver_if bus_a ();
  seg_scan_driver_if bus_b ();

  assign bus_a.en = en_a;
  assign bus_a.d1 = dv[0];
  assign bus_a.d2 = dv[1];
  assign bus_a.d3 = dv[2];
  assign bus_a.d4 = dv[3];
  assign bus_a.d5 = dv[4];
  assign bus_a.d6 = dv[5];
  assign bus_b.en = en_b;
  assign bus_b.d1 = dv[0];
  assign bus_b.d2 = dv[1];
  assign bus_b.d3 = dv[2];
  assign bus_b.d4 = dv[3];
  assign bus_b.d5 = dv[4];
  assign bus_b.d6 = dv[5];

  seg_scan_driver #(
    .CLK_DIV(DIV), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  seg_scan_driver #(
    .CLK_DIV(DIV), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {seg, dig_en, frame_done} for one clock at position pos in the frame.
  function automatic logic [13:0] exp_out(int pos, logic [5:0][6:0] snap, int blank,
                                          bit seg_al, bit fd);
    int dig, w;
    logic [6:0] s;
    logic [5:0] de;
    dig = pos / DIV;
    w   = pos % DIV;
    if (w < blank) begin
      s  = seg_al ? 7'h7F : 7'h00;
      de = 6'h3F;
    end else begin
      s  = seg_al ? ~snap[dig] : snap[dig];
      de = ~(6'b000001 << dig);
    end
    return {s, de, fd};
  endfunction

  logic [13:0] q_a [$];
  logic [13:0] q_b [$];
  int pos_a, pos_b;
  bit run_a = 0, run_b = 0;
  bit fd_a, fd_b;
  logic [5:0][6:0] snap_a, snap_b;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) run_a = 0;
    else if (!en_a) begin
      run_a = 0;
      q_a.push_back({7'h7F, 6'h3F, 1'b0});
    end else begin
      fd_a = 0;
      if (!run_a) begin
        run_a = 1;
        pos_a = 0;
      end else begin
        pos_a = (pos_a + 1) % FRAME;
        fd_a  = (pos_a == 0);
      end
      if (pos_a == 0) for (int i = 0; i < 6; i++) snap_a[i] = dv[i];
      q_a.push_back(exp_out(pos_a, snap_a, 1, 1'b1, fd_a));
    end
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) run_b = 0;
    else if (!en_b) begin
      run_b = 0;
      q_b.push_back({7'h00, 6'h3F, 1'b0});
    end else begin
      fd_b = 0;
      if (!run_b) begin
        run_b = 1;
        pos_b = 0;
      end else begin
        pos_b = (pos_b + 1) % FRAME;
        fd_b  = (pos_b == 0);
      end
      if (pos_b == 0) for (int i = 0; i < 6; i++) snap_b[i] = dv[i];
      q_b.push_back(exp_out(pos_b, snap_b, 0, 1'b0, fd_b));
    end
  end

  always @(negedge clk) begin
    logic [13:0] e;
    cyc++;
    if (rst_a) begin
      check_eq("a_rst_seg", 32'(bus_a.seg), 32'h7F);
      check_eq("a_rst_dig", 32'(bus_a.dig_en), 32'h3F);
      check_eq("a_rst_fd", 32'(bus_a.frame_done), 32'h0);
    end else if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check_eq($sformatf("a_cyc%0d", cyc), 32'({bus_a.seg, bus_a.dig_en, bus_a.frame_done}),
               32'(e));
    end
    if (rst_b) begin
      check_eq("b_rst_seg", 32'(bus_b.seg), 32'h00);
      check_eq("b_rst_dig", 32'(bus_b.dig_en), 32'h3F);
    end else if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check_eq($sformatf("b_cyc%0d", cyc), 32'({bus_b.seg, bus_b.dig_en, bus_b.frame_done}),
               32'(e));
      if (en_b) check_eq($sformatf("b_onehot%0d", cyc), 32'($countones(~bus_b.dig_en)), 32'd1);
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    en_a  = 1'b1;
    en_b  = 1'b1;
    dv[0] = GLYPH_1;
    dv[1] = GLYPH_2;
    dv[2] = GLYPH_3;
    dv[3] = GLYPH_4;
    dv[4] = GLYPH_5;
    dv[5] = GLYPH_6;

    // Reset held with en high: outputs stay off.
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Mid-frame pattern change only shows up in the following frame.
    repeat (11) @(negedge clk);
    dv[0] = GLYPH_0;

    // Drop en during digit 3 SHOW, hold low, then restart with fresh patterns.
    repeat (51) @(negedge clk);
    en_a = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) dv[i] = 7'($urandom_range(0, 127));
    en_a = 1'b1;
    repeat (39) @(negedge clk);

    // Asynchronous reset pulse between clock edges.
    #1 rst_a = 1'b1;
    #1;
    check_eq("a_async_seg", 32'(bus_a.seg), 32'h7F);
    check_eq("a_async_dig", 32'(bus_a.dig_en), 32'h3F);
    check_eq("a_async_fd", 32'(bus_a.frame_done), 32'h0);
    #1 rst_a = 1'b0;

    repeat (10) @(negedge clk);
    dv[3] = 7'($urandom_range(0, 127));
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
